// File: rtl/load_store_unit_if.sv
// Request/response and RAM port-B bundle for load_store_unit.
// slave = LSU side, master = core/RAM side.
interface load_store_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_din_o;
    logic [31:0] mem_dout_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_dout_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o, mem_en_o, mem_we_o, mem_din_o
    );
    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_dout_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o, mem_en_o, mem_we_o, mem_din_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store engine on RAM port B; sub-word stores use read-modify-write.
// Optional: LSU_MISALIGN_ERR_EN turns misaligned half/word accesses into errors instead of clearing low bits.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input logic               clk,
    input logic               rst_i,
    load_store_unit_if.slave  bus
);
    localparam logic [32:0] MEM_LIM = 33'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        req;
    logic [31:0] rdword, rsp_rdata;
    logic        rsp_err;

    logic        accept, misalign, req_err;
    logic [31:0] eff_addr;
    logic [32:0] last_byte;
    logic [1:0]  nb_m1;

    assign accept = (state == IDLE) && bus.req_valid_i;

    // Request qualification: alignment policy, then range/size check on the effective address.
    always_comb begin
        eff_addr = bus.req_addr_i;
        misalign = 1'b0;
`ifdef LSU_MISALIGN_ERR_EN
        misalign = ((bus.req_size_i == 2'b01) && bus.req_addr_i[0]) ||
                   ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
`else
        if (bus.req_size_i == 2'b01) eff_addr[0]   = 1'b0;
        if (bus.req_size_i == 2'b10) eff_addr[1:0] = 2'b00;
`endif
        case (bus.req_size_i)
            2'b01:   nb_m1 = 2'd1;
            2'b10:   nb_m1 = 2'd3;
            default: nb_m1 = 2'd0;
        endcase
        last_byte = {1'b0, eff_addr} + {31'b0, nb_m1};
        req_err   = (bus.req_size_i == 2'b11) || (last_byte >= MEM_LIM) || misalign;
    end

    always_ff @(posedge clk or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) begin
                       if (req_err)                     state_nxt = RESP;
                       else if (!bus.req_we_i)          state_nxt = READ;
                       else if (bus.req_size_i == 2'b10) state_nxt = WRITE;
                       else                             state_nxt = READ;
                   end
            READ:  state_nxt = req.we ? WRITE : RESP;
            WRITE: state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = (state == IDLE);
        bus.rsp_valid_o = (state == RESP);
        bus.mem_en_o    = (state == READ) || (state == WRITE);
        bus.mem_we_o    = (state == WRITE) ? 4'b1111 : 4'b0000;
    end

    // Load extraction straight from the RAM word during READ.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    always_comb begin
        ld_byte = bus.mem_dout_i[{req.addr[1:0], 3'b000} +: 8];
        ld_half = bus.mem_dout_i[{req.addr[1], 4'b0000} +: 16];
        case (req.size)
            2'b00:   ld_ext = req.uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = req.uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = bus.mem_dout_i;
        endcase
    end

    // Store merge: each byte lane takes new data when selected, else keeps the read word.
    logic [3:0][7:0] merged;
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic sel;
        always_comb begin
            case (req.size)
                2'b00:   sel = (req.addr[1:0] == 2'(i));
                2'b01:   sel = (req.addr[1] == 1'(i / 2));
                default: sel = 1'b1;
            endcase
            if (!sel)                 merged[i] = rdword[8*i +: 8];
            else if (req.size == 2'b10) merged[i] = req.wdata[8*i +: 8];
            else if (req.size == 2'b01) merged[i] = req.wdata[8*(i%2) +: 8];
            else                      merged[i] = req.wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            req       <= '0;
            rdword    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept)
                req <= '{we: bus.req_we_i, size: bus.req_size_i, uns: bus.req_unsigned_i,
                         addr: eff_addr, wdata: bus.req_wdata_i};
            if (state == READ)
                rdword <= bus.mem_dout_i;
            // Response fields change only on entry to RESP so they hold between responses.
            if (state_nxt == RESP && state != RESP) begin
                rsp_err   <= (state == IDLE);
                rsp_rdata <= (state == READ) ? ld_ext : 32'b0;
            end
        end
    end

    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.mem_addr_o  = {req.addr[31:2], 2'b00};
    assign bus.mem_din_o   = merged;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a behavioural 4 KiB RAM on port B.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit #(.MEM_BYTES(4096)) dut (.clk(clk), .rst_i(rst_i), .bus(bus));

    logic [31:0] mem [0:1023];
    always @(posedge clk)
        if (bus.mem_en_o && bus.mem_we_o == 4'b1111) mem[bus.mem_addr_o[11:2]] <= bus.mem_din_o;
    assign bus.mem_dout_i = mem[bus.mem_addr_o[11:2]];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_din;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                                input logic [31:0] e_din);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.e_rdata = e_rdata; v.e_err = e_err; v.e_lat = e_lat; v.e_din = e_din;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic run_vec(input string tag, input vec_t v);
        int w = 0, lat = 0, we_cnt = 0;
        logic en_seen = 1'b0;
        logic [31:0] din = '0, rd = '0;
        logic er = 1'b0;
        bus.req_valid_i = 1'b1; bus.req_we_i = v.we; bus.req_size_i = v.size;
        bus.req_unsigned_i = v.uns; bus.req_addr_i = v.addr; bus.req_wdata_i = v.wdata;
        while (!bus.req_ready_o && w < 8) begin @(negedge clk); w++; end
        if (!bus.req_ready_o) begin
            chk({tag, " ready"}, 32'(bus.req_ready_o), 32'd1);
            bus.req_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1 bus.req_valid_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_en_o) en_seen = 1'b1;
            if (bus.mem_we_o == 4'b1111) begin we_cnt++; din = bus.mem_din_o; end
            if (bus.rsp_valid_o) begin lat = c; rd = bus.rsp_rdata_o; er = bus.rsp_err_o; break; end
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.e_lat));
        chk({tag, " err"}, 32'(er), 32'(v.e_err));
        chk({tag, " rdata"}, rd, v.e_rdata);
        chk({tag, " mem_en"}, 32'(en_seen), 32'(!v.e_err));
        chk({tag, " we cycles"}, 32'(we_cnt), (v.we && !v.e_err) ? 32'd1 : 32'd0);
        if (v.we && !v.e_err) chk({tag, " din"}, din, v.e_din);
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;

        tbl.push_back(mk(1, 2'b10, 0, 32'h40,  32'hDEADBEEF, 32'h0,        0, 2, 32'hDEADBEEF));
        tbl.push_back(mk(0, 2'b10, 0, 32'h40,  32'h0,        32'hDEADBEEF, 0, 2, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h44,  32'h11223344, 32'h0,        0, 2, 32'h11223344));
        tbl.push_back(mk(1, 2'b00, 0, 32'h46,  32'hFFFFFFAA, 32'h0,        0, 3, 32'h11AA3344));
        tbl.push_back(mk(0, 2'b10, 0, 32'h44,  32'h0,        32'h11AA3344, 0, 2, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h48,  32'h80F07F01, 32'h0,        0, 2, 32'h80F07F01));
        tbl.push_back(mk(0, 2'b00, 0, 32'h4B,  32'h0,        32'hFFFFFF80, 0, 2, 32'h0));
        tbl.push_back(mk(0, 2'b00, 1, 32'h4B,  32'h0,        32'h00000080, 0, 2, 32'h0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h48,  32'h0,        32'h00007F01, 0, 2, 32'h0));
        tbl.push_back(mk(0, 2'b01, 1, 32'h4A,  32'h0,        32'h000080F0, 0, 2, 32'h0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h4A,  32'h0,        32'hFFFF80F0, 0, 2, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h1000,32'h0,        32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(0, 2'b11, 0, 32'h40,  32'h0,        32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'hFFC, 32'hCAFEF00D, 32'h0,        0, 2, 32'hCAFEF00D));
        tbl.push_back(mk(0, 2'b01, 1, 32'hFFE, 32'h0,        32'h0000CAFE, 0, 2, 32'h0));
        tbl.push_back(mk(0, 2'b00, 1, 32'hFFF, 32'h0,        32'h000000CA, 0, 2, 32'h0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h1000,32'h0,        32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h1000,32'h12,       32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h50,  32'h55667788, 32'h0,        0, 2, 32'h55667788));
`ifdef LSU_MISALIGN_ERR_EN
        tbl.push_back(mk(0, 2'b01, 0, 32'hFFF, 32'h0,        32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(1, 2'b01, 0, 32'h51,  32'h1234,     32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h50,  32'h0,        32'h55667788, 0, 2, 32'h0));
        tbl.push_back(mk(1, 2'b01, 0, 32'h52,  32'hABCD,     32'h0,        0, 3, 32'hABCD7788));
        tbl.push_back(mk(0, 2'b10, 0, 32'h50,  32'h0,        32'hABCD7788, 0, 2, 32'h0));
`else
        tbl.push_back(mk(0, 2'b01, 0, 32'hFFF, 32'h0,        32'hFFFFCAFE, 0, 2, 32'h0));
        tbl.push_back(mk(1, 2'b01, 0, 32'h51,  32'h1234,     32'h0,        0, 3, 32'h55661234));
        tbl.push_back(mk(0, 2'b10, 0, 32'h50,  32'h0,        32'h55661234, 0, 2, 32'h0));
        tbl.push_back(mk(1, 2'b01, 0, 32'h52,  32'hABCD,     32'h0,        0, 3, 32'hABCD1234));
        tbl.push_back(mk(0, 2'b10, 0, 32'h50,  32'h0,        32'hABCD1234, 0, 2, 32'h0));
`endif
        tbl.push_back(mk(1, 2'b10, 0, 32'h60,  32'h0BADF00D, 32'h0,        0, 2, 32'h0BADF00D));

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst err", 32'(bus.rsp_err_o), 32'd0);
        chk("rst rdata", bus.rsp_rdata_o, 32'd0);
        chk("rst mem_en", 32'(bus.mem_en_o), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Async reset in the middle of a word store: write must be dropped.
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'b10;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h60; bus.req_wdata_i = 32'h99999999;
        chk("b2b ready in RESP", 32'(bus.req_ready_o), 32'd0);
        @(negedge clk);
        chk("b2b ready in IDLE", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk); #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("abort we in WRITE", 32'(bus.mem_we_o), 32'hF);
        rst_i = 1'b1;
        #1;
        chk("abort we dropped", 32'(bus.mem_we_o), 32'd0);
        chk("abort en dropped", 32'(bus.mem_en_o), 32'd0);
        chk("abort rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        chk("abort rdata cleared", bus.rsp_rdata_o, 32'd0);
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post-abort rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
            chk("post-abort ready", 32'(bus.req_ready_o), 32'd1);
        end
        run_vec("abort readback", mk(0, 2'b10, 0, 32'h60, 32'h0, 32'h0BADF00D, 0, 2, 32'h0));

        // Response is a single-cycle pulse and rdata holds afterwards.
        @(negedge clk);
        chk("pulse end", 32'(bus.rsp_valid_o), 32'd0);
        chk("rdata hold", bus.rsp_rdata_o, 32'h0BADF00D);
        @(negedge clk);
        chk("rdata hold 2", bus.rsp_rdata_o, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
